// File: rtl/phase_measure.sv
// phase_measure: recovers period, phase shift and high time of meas_clk
// relative to ref_clk, counted in clk cycles, and declares lock once
// successive measurements agree within TOL.
module phase_measure #(
  parameter int CNT_W      = 16,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             en,
  input  logic             ref_clk,
  input  logic             meas_clk,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] shift_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             valid,
  output logic             err,
  output logic             lock
);

  localparam int               MW       = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_MAX = MW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t           state;
  logic [2:0]       ref_sync;
  logic [2:0]       meas_sync;
  logic             ref_rise;
  logic             meas_rise;
  logic             meas_fall;
  logic [CNT_W-1:0] wc;
  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] s_tmp;
  logic [CNT_W-1:0] h_tmp;
  logic             shift_seen;
  logic [MW-1:0]    mcnt;
  logic [MW-1:0]    mcnt_inc;
  logic             have_prev;
  logic [CNT_W-1:0] prev_period;
  logic [CNT_W-1:0] prev_shift;
  logic [CNT_W-1:0] shift_res;
  logic             period_ok;
  logic             shift_ok;
  logic             is_match;

  // Unsigned distance between two counts, computed one bit wider so the
  // borrow tells us which way round to negate.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic [CNT_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[CNT_W] ? (~d + 1'b1) : d;
  endfunction

  // Two synchronizer flops plus one history flop per input clock.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      ref_sync  <= 3'b000;
      meas_sync <= 3'b000;
    end else begin
      ref_sync  <= {ref_sync[1:0], ref_clk};
      meas_sync <= {meas_sync[1:0], meas_clk};
    end
  end

  assign ref_rise  = ref_sync[1] & ~ref_sync[2];
  assign meas_rise = meas_sync[1] & ~meas_sync[2];
  assign meas_fall = ~meas_sync[1] & meas_sync[2];

  // High-time counter runs free of the windows so a pulse may straddle ref edges.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      hc    <= '0;
      h_tmp <= '0;
    end else begin
      if (meas_rise)
        hc <= CNT_ONE;
      else if (hc != CNT_MAX)
        hc <= hc + CNT_ONE;
      if (meas_fall)
        h_tmp <= hc;
    end
  end

  assign shift_res = shift_seen ? s_tmp : '0;
  assign period_ok = abs_diff(wc, prev_period) <= TOL_W;
  assign shift_ok  = abs_diff(shift_res, prev_shift) <= TOL_W;
  assign is_match  = have_prev && shift_seen && period_ok && shift_ok;
  assign mcnt_inc  = (mcnt == LOCK_MAX) ? LOCK_MAX : mcnt + MW'(1);

  // Window FSM: counts ref periods, captures shift, publishes results and tracks lock.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      wc          <= '0;
      s_tmp       <= '0;
      shift_seen  <= 1'b0;
      mcnt        <= '0;
      have_prev   <= 1'b0;
      prev_period <= '0;
      prev_shift  <= '0;
      period_cnt  <= '0;
      shift_cnt   <= '0;
      high_cnt    <= '0;
      valid       <= 1'b0;
      err         <= 1'b0;
      lock        <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      valid     <= 1'b0;
      lock      <= 1'b0;
      mcnt      <= '0;
      have_prev <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          state     <= ARM;
          have_prev <= 1'b0;
        end
        ARM: begin
          if (ref_rise) begin
            state      <= MEAS;
            wc         <= CNT_ONE;
            shift_seen <= meas_rise;
            s_tmp      <= '0;
          end
        end
        MEAS: begin
          if (ref_rise) begin
            period_cnt  <= wc;
            shift_cnt   <= shift_res;
            high_cnt    <= h_tmp;
            err         <= !shift_seen;
            valid       <= 1'b1;
            prev_period <= wc;
            prev_shift  <= shift_res;
            have_prev   <= 1'b1;
            if (is_match) begin
              mcnt <= mcnt_inc;
              lock <= (mcnt_inc == LOCK_MAX);
            end else begin
              mcnt <= '0;
              lock <= 1'b0;
            end
            wc         <= CNT_ONE;
            shift_seen <= meas_rise;
            s_tmp      <= '0;
          end else if (wc == CNT_MAX) begin
            valid       <= 1'b1;
            err         <= 1'b1;
            period_cnt  <= CNT_MAX;
            lock        <= 1'b0;
            mcnt        <= '0;
            prev_period <= CNT_MAX;
            prev_shift  <= shift_cnt;
            have_prev   <= 1'b0;
            state       <= ARM;
          end else begin
            wc <= wc + CNT_ONE;
            if (meas_rise && !shift_seen) begin
              shift_seen <= 1'b1;
              s_tmp      <= wc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_measure.sv
// tb_phase_measure: drives ref_clk/meas_clk waveforms window by window,
// predicts each result from the waveform parameters and compares in a
// decoupled monitor.
`timescale 1ns/1ps
module tb_phase_measure;

  localparam int CNT_W      = 8;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int ACT_NONE   = 0;
  localparam int ACT_EN     = 1;
  localparam int ACT_RST    = 2;

  logic             clk = 1'b0;
  logic             RST_N = 1'b0;
  logic             en = 1'b0;
  logic             ref_clk = 1'b0;
  logic             meas_clk = 1'b0;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] shift_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             valid;
  logic             err;
  logic             lock;

  phase_measure #(.CNT_W(CNT_W), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk(clk), .RST_N(RST_N), .en(en), .ref_clk(ref_clk), .meas_clk(meas_clk),
    .period_cnt(period_cnt), .shift_cnt(shift_cnt), .high_cnt(high_cnt),
    .valid(valid), .err(err), .lock(lock)
  );

  // 1 ns sampling clock: rises at x.5, falls at integer ns where the
  // stimulus changes and the outputs are sampled.
  always #0.5 clk = ~clk;

  typedef struct {
    int period;
    int shift;
    int high;
    bit err;
    bit lock;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp;
  int   checks = 0;
  int   fails  = 0;

  // Reference model state: 0 idle, 1 armed, 2 inside a window.
  int mstate = 0;
  int cur_p = 0, cur_s = 0;
  bit cur_miss = 0;
  int last_high = 0;
  int out_period = 0, out_shift = 0, out_high = 0;
  bit out_err = 0;
  bit have_prev = 0;
  int prev_p = 0, prev_s = 0;
  int streak = 0;
  int tnow = 0;
  int pend_fall = -1;
  int pend_h = 0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: actual %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // A window closed normally: shift and high come from the waveform that was drawn.
  task automatic pushResult(input int p, input int s, input int h, input bit e);
    bit m;
    m = !e && have_prev && (iabs(p - prev_p) <= TOL) && (iabs(s - prev_s) <= TOL);
    streak = m ? ((streak < LOCK_COUNT) ? streak + 1 : LOCK_COUNT) : 0;
    exp_q.push_back('{period: p, shift: s, high: h, err: e, lock: (streak == LOCK_COUNT)});
    prev_p = p; prev_s = s; have_prev = 1;
    out_period = p; out_shift = s; out_high = h; out_err = e;
  endtask

  // A window longer than the counter range: saturated period, other results held.
  task automatic pushOverflow();
    exp_q.push_back('{period: CNT_MAX, shift: out_shift, high: out_high, err: 1'b1, lock: 1'b0});
    streak = 0; have_prev = 0;
    prev_p = CNT_MAX; prev_s = out_shift;
    out_period = CNT_MAX; out_err = 1;
  endtask

  // One ref period of p ns; meas rises s ns after ref and stays high h ns
  // unless miss; act optionally drops en or pulses reset in the ref-low phase.
  task automatic applyStimulus(input int p, input int s, input int h, input bit miss,
                               input int act);
    int a;
    a = (3 * p) / 5;
    for (int t = 0; t < p; t++) begin
      if (pend_fall == tnow) begin
        meas_clk = 1'b0;
        last_high = pend_h;
        pend_fall = -1;
      end
      if (t == 0) begin
        ref_clk = 1'b1;
        if (mstate == 2) pushResult(cur_p, cur_miss ? 0 : cur_s, last_high, cur_miss);
        if (mstate != 0) begin
          mstate = 2; cur_p = p; cur_s = s; cur_miss = miss;
          if (p > CNT_MAX) begin
            pushOverflow();
            mstate = 1;
          end
        end
      end
      if (t == p / 2) ref_clk = 1'b0;
      if (!miss && t == s) begin
        meas_clk = 1'b1;
        pend_fall = tnow + h;
        pend_h = h;
      end
      if (act == ACT_EN && t == a) begin
        en = 1'b0;
        mstate = 0; have_prev = 0; streak = 0;
      end
      if (act == ACT_EN && t == a + 1) begin
        checkOutput("en_drop_lock", int'(lock), 0);
        checkOutput("en_drop_period_hold", int'(period_cnt), out_period);
        checkOutput("en_drop_shift_hold", int'(shift_cnt), out_shift);
        checkOutput("en_drop_high_hold", int'(high_cnt), out_high);
        checkOutput("en_drop_err_hold", int'(err), int'(out_err));
      end
      if (act == ACT_EN && t == a + 8) begin
        en = 1'b1;
        mstate = 1;
      end
      if (act == ACT_RST && t == a + 4) RST_N = 1'b1;
      if (act == ACT_RST && t == a) begin
        RST_N = 1'b0;
        #0.25;
        checkOutput("async_reset_period", int'(period_cnt), 0);
        checkOutput("async_reset_shift", int'(shift_cnt), 0);
        checkOutput("async_reset_high", int'(high_cnt), 0);
        checkOutput("async_reset_valid", int'(valid), 0);
        checkOutput("async_reset_err", int'(err), 0);
        checkOutput("async_reset_lock", int'(lock), 0);
        mstate = 1; have_prev = 0; streak = 0; last_high = 0;
        prev_p = 0; prev_s = 0;
        out_period = 0; out_shift = 0; out_high = 0; out_err = 0;
        #0.75;
      end else begin
        #1;
      end
      tnow++;
    end
  endtask

  task automatic runSegment(input int n, input int p, input int s, input int h, input bit miss);
    for (int i = 0; i < n; i++) applyStimulus(p, s, h, miss, ACT_NONE);
  endtask

  // Monitor: every valid pulse is matched against the oldest prediction.
  always @(negedge clk) begin
    if (RST_N && valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_valid: actual valid=1, required no result pending (t=%0t)", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("period_cnt", int'(period_cnt), mon_exp.period);
        checkOutput("shift_cnt", int'(shift_cnt), mon_exp.shift);
        checkOutput("high_cnt", int'(high_cnt), mon_exp.high);
        checkOutput("err", int'(err), int'(mon_exp.err));
        checkOutput("lock", int'(lock), int'(mon_exp.lock));
      end
    end
  end

  // Main stimulus sequence: directed scenarios followed by random windows.
  initial begin
    int p, s, h, n;
    bit miss;
    #3;
    checkOutput("reset_period", int'(period_cnt), 0);
    checkOutput("reset_shift", int'(shift_cnt), 0);
    checkOutput("reset_high", int'(high_cnt), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_lock", int'(lock), 0);
    RST_N = 1'b1;
    #2;
    en = 1'b1;
    mstate = 1;
    #5;
    tnow = 10;

    $display("[TB] nominal 90 deg, 50%% duty");
    runSegment(8, 100, 25, 50, 0);
    $display("[TB] shift step 25 -> 40");
    runSegment(7, 100, 40, 50, 0);
    $display("[TB] missing meas window then re-acquire");
    runSegment(1, 100, 25, 50, 1);
    runSegment(7, 100, 25, 50, 0);
    $display("[TB] shift 75, 30%% duty; straddling pulse");
    runSegment(6, 100, 75, 30, 0);
    runSegment(6, 100, 90, 50, 0);
    runSegment(1, 100, 0, 0, 1);
    $display("[TB] en dropped while locked");
    runSegment(6, 100, 10, 40, 0);
    applyStimulus(100, 10, 40, 0, ACT_EN);
    runSegment(6, 100, 10, 40, 0);
    $display("[TB] async reset mid-window");
    applyStimulus(100, 10, 40, 0, ACT_RST);
    runSegment(6, 100, 25, 50, 0);
    $display("[TB] counter overflow");
    applyStimulus(300, 25, 50, 0, ACT_NONE);
    runSegment(6, 100, 25, 50, 0);
    $display("[TB] random windows");
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 4);
      p = ($urandom_range(0, 19) == 0) ? $urandom_range(260, 320) : $urandom_range(40, 200);
      h = $urandom_range(5, p / 2);
      s = $urandom_range(0, p - h - 3);
      miss = ($urandom_range(0, 9) == 0);
      runSegment(n, p, s, h, miss);
    end
    en = 1'b0;
    mstate = 0;
    #20;
    checkOutput("pending_results", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    fails++;
    $display("[TB] FAIL watchdog: actual time limit reached, required end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
